// File: rtl/sigma_arbiter.sv
// sigma_arbiter: shares one sigma core between two requesters.
// Round-robin grant with a valid/ready handshake per requester. Jobs go to the
// core as single-cycle core_tvalid pulses, spaced by ISSUE_GAP idle cycles and
// capped at MAX_OUT in flight. An in-order tag FIFO routes each core result
// back to the requester that issued it.
// Optional build macro SIGMA_ARB_TIMEOUT_EN adds a watchdog. It flushes the
// tag FIFO when the core stays silent for TIMEOUT cycles, and it adds a
// one-cycle 'timeout' output pulse.
module sigma_arbiter #(
  parameter int PRECISION = 32,
  parameter int MAX_OUT   = 4,
  parameter int ISSUE_GAP = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [9*PRECISION-1:0]        req0_mat,
  input  logic [9*PRECISION-1:0]        req1_mat,
  input  logic [PRECISION-1:0]          req0_err,
  input  logic [PRECISION-1:0]          req1_err,
  output logic                          core_tvalid,
  output logic [9*PRECISION-1:0]        core_mat,
  output logic [PRECISION-1:0]          core_err,
  input  logic                          core_valid,
  input  logic [PRECISION-1:0]          core_sigma,
  output logic [1:0]                    rsp_valid,
  output logic [PRECISION-1:0]          rsp_sigma,
  output logic [$clog2(MAX_OUT+1)-1:0]  outstanding,
`ifdef SIGMA_ARB_TIMEOUT_EN
  output logic                          timeout,
`endif
  output logic                          err_unexp
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);
  localparam logic [3:0]       GAP_LAST = 4'((ISSUE_GAP > 0) ? ISSUE_GAP - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               rr;         // requester that wins a tie
  logic               grant_id;   // requester offered ready this cycle
  logic               job_id;     // requester of the job being issued
  logic               hs;
  logic [3:0]         gap_cnt;
  logic               push;
  logic               pop;
  logic               flush;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               tag_mem [MAX_OUT];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Pick the candidate requester: the lone valid one, otherwise the rr pointer.
  always_comb begin
    grant_id = rr;
    if (req_valid == 2'b01) begin
      grant_id = 1'b0;
    end else if (req_valid == 2'b10) begin
      grant_id = 1'b1;
    end
  end

  // Next-state and handshake/strobe outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned (no latch).
    state_nxt   = state;
    req_ready   = 2'b00;
    core_tvalid = 1'b0;
    case (state)
      IDLE: begin
        // Ready is held low while reset is asserted, so no handshake happens then.
        if ((count < CNT_MAX) && !reset) begin
          req_ready = grant_id ? 2'b10 : 2'b01;
          if (req_valid[grant_id]) begin
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        core_tvalid = 1'b1;
        state_nxt   = (ISSUE_GAP > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A watchdog flush abandons an issue/gap sequence. A handshake in IDLE still completes.
    if (flush && (state != IDLE)) begin
      state_nxt = IDLE;
    end
  end

  assign hs = |(req_valid & req_ready);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment only, so every flop samples pre-edge values.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Count idle cycles in GAP. Cleared while the job is being issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (state == ISSUE) begin
      gap_cnt <= '0;
    end else if (state == GAP) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  // Latch the granted job and hand round-robin priority to the other requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_mat <= '0;
      core_err <= '0;
      job_id   <= 1'b0;
      rr       <= 1'b0;
    end else if (hs) begin
      core_mat <= grant_id ? req1_mat : req0_mat;
      core_err <= grant_id ? req1_err : req0_err;
      job_id   <= grant_id;
      rr       <= ~grant_id;
    end
  end

  // A tag is pushed as the job goes out. A tag is popped when a result returns and a tag is waiting.
  assign push = (state == ISSUE) && !flush;
  assign pop  = core_valid && (count != '0) && !flush;

  // In-order tag FIFO: pointers wrap modulo MAX_OUT, and a separate count gives full/empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: the tag store is at most 16 single-bit entries, so it is reset with the pointers.
      for (int i = 0; i < MAX_OUT; i++) begin
        tag_mem[i] <= 1'b0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= job_id;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign outstanding = count;

  // Registered result routing: one-cycle pulse to the requester at the FIFO head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 2'b00;
      rsp_sigma <= '0;
    end else begin
      rsp_valid <= 2'b00;
      if (pop) begin
        rsp_valid <= tag_mem[rd_ptr] ? 2'b10 : 2'b01;
        rsp_sigma <= core_sigma;
      end
    end
  end

  // Sticky flag: a result arrived with no job recorded as in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_unexp <= 1'b0;
    end else if (core_valid && (count == '0)) begin
      err_unexp <= 1'b1;
    end
  end

`ifdef SIGMA_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt;

  // Watchdog: counts silent cycles while jobs are in flight. Any result restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (core_valid || (count == '0) || timeout) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign timeout = (count != '0) && !core_valid && (wd_cnt == WD_LAST);
  assign flush   = timeout;
`else
  assign flush = 1'b0;
`endif

endmodule

// File: tb/tb_sigma_arbiter.sv
// tb_sigma_arbiter: directed scoreboard bench for sigma_arbiter.
// Stimulus pushes each expected result (requester id and sigma) into a queue.
// A negedge monitor pops the queue and compares whenever rsp_valid pulses.
module tb_sigma_arbiter;

  localparam int P  = 32;
  localparam int MW = 9 * P;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [MW-1:0]  req0_mat, req1_mat;
  logic [P-1:0]   req0_err, req1_err;
  logic           core_tvalid;
  logic [MW-1:0]  core_mat;
  logic [P-1:0]   core_err;
  logic           core_valid;
  logic [P-1:0]   core_sigma;
  logic [1:0]     rsp_valid;
  logic [P-1:0]   rsp_sigma;
  logic [2:0]     outstanding;
  logic           err_unexp;
`ifdef SIGMA_ARB_TIMEOUT_EN
  logic           timeout;
`endif

  sigma_arbiter #(
    .PRECISION(P),
    .MAX_OUT  (4),
    .ISSUE_GAP(1),
    .TIMEOUT  (1024)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_mat   (req0_mat),
    .req1_mat   (req1_mat),
    .req0_err   (req0_err),
    .req1_err   (req1_err),
    .core_tvalid(core_tvalid),
    .core_mat   (core_mat),
    .core_err   (core_err),
    .core_valid (core_valid),
    .core_sigma (core_sigma),
    .rsp_valid  (rsp_valid),
    .rsp_sigma  (rsp_sigma),
    .outstanding(outstanding),
`ifdef SIGMA_ARB_TIMEOUT_EN
    .timeout    (timeout),
`endif
    .err_unexp  (err_unexp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         id;
    logic [P-1:0] sigma;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [MW-1:0] mat_a, mat_b;
  logic [P-1:0]  err_a, err_b;
  int            n_iss;
  int            iss_cyc [8];
  logic [MW-1:0] iss_mat [8];
  bit            ok;

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Returns at the negedge of the next cycle with core_tvalid high, or flags a failure.
  task automatic wait_tvalid(input string name, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (core_tvalid) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: core_tvalid not seen within %0d cycles", name, budget);
    end
  endtask

  // Presents one core result and records where it must come back.
  task automatic core_result(input logic id, input logic [P-1:0] s);
    core_valid = 1'b1;
    core_sigma = s;
    exp_q.push_back('{id: id, sigma: s});
    tick();
    core_valid = 1'b0;
  endtask

  // Monitor: every response pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rsp_valid !== 2'b00) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: rsp_valid=%b rsp_sigma=%h, expected no response", rsp_valid, rsp_sigma);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_route", MW'(rsp_valid), MW'(e.id ? 2'b10 : 2'b01));
        check("rsp_sigma", MW'(rsp_sigma), MW'(e.sigma));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not finish in time");
    $fatal(1, "global watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 2'b00;
    req0_mat   = '0;
    req1_mat   = '0;
    req0_err   = '0;
    req1_err   = '0;
    core_valid = 1'b0;
    core_sigma = '0;

    // Test-plan matrix: A01=A21, A02=A20, A10=A12, rest zero.
    mat_a = '0;
    mat_a[1*P +: P] = 32'h3f000000;
    mat_a[7*P +: P] = 32'h3f000000;
    mat_a[2*P +: P] = 32'h3d4ccccd;
    mat_a[6*P +: P] = 32'h3d4ccccd;
    mat_a[3*P +: P] = 32'h3eaaaaaa;
    mat_a[5*P +: P] = 32'h3eaaaaaa;
    err_a = 32'h3dcccccd;
    for (int k = 0; k < 9; k++) mat_b[k*P +: P] = 32'h3f800000 + k;
    err_b = 32'h3c23d70a;

    // ---- reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_core_tvalid", MW'(core_tvalid), '0);
    check("rst_rsp_valid",   MW'(rsp_valid),   '0);
    check("rst_outstanding", MW'(outstanding), '0);
    check("rst_err_unexp",   MW'(err_unexp),   '0);
    check("rst_core_mat",    core_mat,         '0);
    check("rst_core_err",    MW'(core_err),    '0);
    check("rst_rsp_sigma",   MW'(rsp_sigma),   '0);
    check("rst_req_ready",   MW'(req_ready),   '0);
    tick();
    reset = 1'b0;

    // ---- single job from requester 0
    req0_mat  = mat_a;
    req0_err  = err_a;
    req_valid = 2'b01;
    @(negedge clk);
    check("t1_req_ready", MW'(req_ready), MW'(2'b01));
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    check("t1_tvalid",   MW'(core_tvalid), MW'(1'b1));
    check("t1_core_mat", core_mat,         mat_a);
    check("t1_core_err", MW'(core_err),    MW'(err_a));
    check("t1_ready_issue", MW'(req_ready), '0);
    tick();
    @(negedge clk);
    check("t1_tvalid_pulse", MW'(core_tvalid), '0);
    check("t1_outstanding",  MW'(outstanding), MW'(1));
    tick();
    core_result(1'b0, 32'h40490fdb);
    @(negedge clk);
    check("t1_rsp_latency", MW'(rsp_valid),   MW'(2'b01));
    check("t1_out_after",   MW'(outstanding), '0);

    // ---- both requesters valid, core silent: alternation, spacing, full limit
    do_reset();
    req0_mat  = mat_a;
    req0_err  = err_a;
    req1_mat  = mat_b;
    req1_err  = err_b;
    req_valid = 2'b11;
    n_iss = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (core_tvalid) begin
        if (n_iss < 8) begin
          iss_cyc[n_iss] = cyc;
          iss_mat[n_iss] = core_mat;
        end
        n_iss++;
      end
      tick();
    end
    check("t2_issue_count", MW'(n_iss), MW'(4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_grant_mat_%0d", i), iss_mat[i], (i % 2 == 0) ? mat_a : mat_b);
      if (i > 0) check($sformatf("t2_issue_gap_%0d", i), MW'(iss_cyc[i] - iss_cyc[i-1]), MW'(3));
    end
    @(negedge clk);
    check("t3_outstanding_full", MW'(outstanding), MW'(4));
    check("t3_ready_full",       MW'(req_ready),   '0);
    tick();
    core_valid = 1'b1;
    core_sigma = 32'h3f8ccccd;
    exp_q.push_back('{id: 1'b0, sigma: 32'h3f8ccccd});
    @(negedge clk);
    check("t3_no_bypass_ready", MW'(req_ready), '0);
    tick();
    core_valid = 1'b0;
    @(negedge clk);
    check("t3_outstanding_pop", MW'(outstanding), MW'(3));
    check("t3_regrant",         MW'(req_ready),   MW'(2'b01));
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    check("t3_reissue_tvalid", MW'(core_tvalid), MW'(1'b1));
    check("t3_reissue_mat",    core_mat,         mat_a);
    tick();
    tick();
    core_result(1'b1, 32'h40000000);
    core_result(1'b0, 32'h40400000);
    core_result(1'b1, 32'h40800000);
    core_result(1'b0, 32'h40a00000);
    tick();
    @(negedge clk);
    check("t3_drained", MW'(outstanding), '0);

    // ---- result coincident with an issue at outstanding=2
    do_reset();
    req_valid = 2'b11;
    wait_tvalid("t4_issue0", 20, ok);
    wait_tvalid("t4_issue1", 20, ok);
    wait_tvalid("t4_issue2", 20, ok);
    check("t4_out_before", MW'(outstanding), MW'(2));
    core_valid = 1'b1;
    core_sigma = 32'h41200000;
    exp_q.push_back('{id: 1'b0, sigma: 32'h41200000});
    tick();
    core_valid = 1'b0;
    req_valid  = 2'b00;
    @(negedge clk);
    check("t4_out_unchanged", MW'(outstanding), MW'(2));
    tick();
    core_result(1'b1, 32'h41300000);
    core_result(1'b0, 32'h41400000);
    @(negedge clk);
    check("t4_drained", MW'(outstanding), '0);

    // ---- unexpected result with nothing in flight
    tick();
    core_valid = 1'b1;
    core_sigma = 32'hdeadbeef;
    tick();
    core_valid = 1'b0;
    @(negedge clk);
    check("t5_err_unexp", MW'(err_unexp), MW'(1'b1));
    check("t5_no_rsp",    MW'(rsp_valid), '0);
    repeat (3) @(negedge clk);
    check("t5_err_sticky", MW'(err_unexp), MW'(1'b1));

    // ---- asynchronous reset during GAP with two jobs in flight
    tick();
    req_valid = 2'b11;
    wait_tvalid("t5_issue0", 20, ok);
    wait_tvalid("t5_issue1", 20, ok);
    tick();
    req_valid = 2'b00;
    check("t5_out_in_gap", MW'(outstanding), MW'(2));
    #1;
    reset = 1'b1;
    #1;
    check("t5_async_outstanding", MW'(outstanding), '0);
    check("t5_async_err_unexp",   MW'(err_unexp),   '0);
    check("t5_async_core_mat",    core_mat,         '0);
    check("t5_async_core_err",    MW'(core_err),    '0);
    check("t5_async_rsp_sigma",   MW'(rsp_sigma),   '0);
    check("t5_async_rsp_valid",   MW'(rsp_valid),   '0);
    check("t5_async_tvalid",      MW'(core_tvalid), '0);
    check("t5_async_ready",       MW'(req_ready),   '0);
    tick();
    reset = 1'b0;
    // A late result for a pre-reset job must be flagged, not routed.
    core_valid = 1'b1;
    core_sigma = 32'h3f000000;
    tick();
    core_valid = 1'b0;
    @(negedge clk);
    check("t5_late_err_unexp", MW'(err_unexp),   MW'(1'b1));
    check("t5_late_out",       MW'(outstanding), '0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", MW'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sigma_arbiter.md
Name: sigma_arbiter

Overview:
- Shares one `sigma` core (3x3 IEEE-754 single-precision matrix in, scalar sigma out, per-job err threshold) between two requesters, e.g. the encrypt and decrypt key-derivation paths of the chaos engine.
- Round-robin arbitration with a valid/ready handshake per requester.
- Issues single-cycle tvalid pulses to the core and enforces a minimum issue gap and an outstanding-job limit.
- Routes each core result back to its originating requester through an in-order tag FIFO.

Parameters:
- PRECISION, 32, float word width (A and err fields, sigma result).
- MAX_OUT, 4, maximum jobs in flight inside the core (tag FIFO depth); 1..16.
- ISSUE_GAP, 1, idle cycles forced between consecutive core_tvalid pulses; 0..15.
- TIMEOUT, 1024, watchdog limit in cycles (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester job valid.
- req_ready  out  2  per-requester accept, combinational from arbiter state.
- req0_mat  in  9*PRECISION  requester 0 matrix, A00 at [PRECISION-1:0] ... A22 at top, row-major.
- req1_mat  in  9*PRECISION  requester 1 matrix, same packing.
- req0_err, req1_err  in  PRECISION  per-job err threshold.
- core_tvalid  out  1  job strobe to sigma core.
- core_mat  out  9*PRECISION  latched matrix to core.
- core_err  out  PRECISION  latched err to core.
- core_valid  in  1  core result strobe.
- core_sigma  in  PRECISION  core result.
- rsp_valid  out  2  one-cycle result pulse per requester; no backpressure.
- rsp_sigma  out  PRECISION  result data, valid with rsp_valid.
- outstanding  out  $clog2(MAX_OUT+1)  jobs in flight.
- err_unexp  out  1  sticky: core_valid arrived with tag FIFO empty.

Behaviour:
- Reset (async, any time, including mid-job):
  - state=IDLE; rr pointer=0 (requester 0 has priority first).
  - core_tvalid, rsp_valid, outstanding, err_unexp, tag FIFO and gap counter all 0.
  - core_mat, core_err, rsp_sigma = 0.
  - Results the core returns for jobs issued before reset hit an empty FIFO and set err_unexp. Integrators reset the core together with this block.
- FSM states: IDLE, ISSUE, GAP.
- IDLE:
  - If outstanding<MAX_OUT, req_ready is asserted for exactly one requester: the one with req_valid high, with ties going to the rr pointer. Otherwise req_ready=0.
  - Handshake = req_valid & req_ready. On handshake: latch mat and err into core_mat/core_err, latch id, flip rr pointer to the other requester, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - core_tvalid=1, core_mat/core_err stable.
  - Push id into tag FIFO; outstanding increments.
  - Next state is GAP if ISSUE_GAP>0, else IDLE.
  - Back-to-back throughput is therefore one job per 2+ISSUE_GAP cycles.
- GAP: req_ready=0; count ISSUE_GAP cycles, then IDLE. core_mat/core_err hold their last value.
- Result path:
  - On core_valid with FIFO non-empty: pop head id. Next cycle, rsp_valid[id]=1 and rsp_sigma=core_sigma (registered, latency 1); outstanding decrements.
  - On core_valid with FIFO empty: no pop, no rsp pulse, err_unexp set (cleared only by reset).
- Simultaneous push (ISSUE) and pop (core_valid) in the same cycle: both performed, outstanding unchanged, FIFO ordering preserved.
- Full: at outstanding==MAX_OUT, req_ready stays 0. A pop in the same cycle frees the slot the following cycle; there is no same-cycle bypass.
- FIFO pointers are $clog2(MAX_OUT)-bit, wrap modulo MAX_OUT, with a separate count for full/empty.
- req_mat/req_err are sampled only at handshake; requesters hold data stable while req_valid=1 and ready=0.

Optional Feature:
- Macro: SIGMA_ARB_TIMEOUT_EN.
- With macro defined:
  - A watchdog counter runs while outstanding>0 and resets on every core_valid.
  - On reaching TIMEOUT it flushes the tag FIFO, sets outstanding=0, pulses output port timeout (1 bit, added only under the macro) for 1 cycle, and returns the FSM to IDLE.
  - Late results after a flush set err_unexp.
- Without macro: no counter and no timeout port; an outstanding job waits indefinitely.

Test Plan:
- Reset, then req_valid=2'b01 with req0_mat A01=A21=0x3f000000, A02=A20=0x3d4ccccd, A10=A12=0x3eaaaaaa, others 0, err=0x3dcccccd -> req_ready[0] same cycle; core_tvalid 1 cycle later with identical core_mat/core_err; core_valid with sigma X -> rsp_valid=2'b01, rsp_sigma=X one cycle later.
- Both requesters continuously valid, ISSUE_GAP=1 -> grants alternate 0,1,0,1; core_tvalid every 3 cycles; results returned in order route to 0,1,0,1.
- MAX_OUT=4, core never responds -> exactly 4 issues, outstanding=4, req_ready held 0; one core_valid -> outstanding=3 and a new grant on the following cycle.
- core_valid coincident with ISSUE cycle at outstanding=2 -> outstanding stays 2; subsequent results still route in issue order.
- core_valid with outstanding=0 -> no rsp_valid, err_unexp=1 until reset; assert reset during GAP with 2 jobs in flight -> all outputs 0 immediately (asynchronous).
- SIGMA_ARB_TIMEOUT_EN, TIMEOUT=16, one job issued, no core response -> timeout pulses 16 cycles after issue, outstanding=0, requester re-granted.
